// File: rtl/adt7031_pkg.sv
// Shared encodings and SPI word layout for the ADT7031 register sequencer.
// The frame is one 16-bit word: {rw, addr[6:0], data[7:0]}, shifted MSB first.
package adt7031_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_LOAD,
        ST_XFER,
        ST_HOLD,
        ST_GAP
    } state_t;

    localparam int SPI_WORD_W = 16;
    localparam int RW_BIT     = 15;
    localparam int ADDR_MSB   = 14;
    localparam int ADDR_LSB   = 8;
    localparam int DATA_MSB   = 7;
    localparam int CNT_W      = 16;

    localparam logic [7:0] SPI_CFG_DEFAULT = 8'h04;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adt7031_cyc_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Loading N-1 on phase entry makes the phase last exactly N cycles.
module adt7031_cyc_timer
    import adt7031_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/adt7031_reg_ctrl.sv
// Frames single register read/write commands as one SPI word with timed enable setup/hold/gap.
// Response is a one-cycle pulse on the last hold cycle with no backpressure; commands wait in IDLE.
module adt7031_reg_ctrl
    import adt7031_pkg::*;
#(
    parameter int         CS_SETUP_CYC = 4,
    parameter int         CS_HOLD_CYC  = 4,
    parameter int         GAP_CYC      = 8,
    parameter int         TIMEOUT_CYC  = 65535,
    parameter logic [7:0] SPI_CFG      = SPI_CFG_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_rw,
    input  logic [6:0]            cmd_addr,
    input  logic [7:0]            cmd_wdata,
    output logic                  rsp_valid,
    output logic [7:0]            rsp_rdata,
    output logic                  rsp_err,
    output logic                  busy,
    output logic                  spi_enable,
    output logic [7:0]            spi_config,
    output logic                  spi_s_tvalid,
    output logic [SPI_WORD_W-1:0] spi_s_tdata,
    input  logic                  spi_s_tready,
    output logic                  spi_m_tready,
    input  logic                  spi_m_tvalid,
    input  logic [SPI_WORD_W-1:0] spi_m_tdata
);

    // The core accepts tvalid only after leaving idle, so setup needs at least two enable cycles.
    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(max_int(CS_SETUP_CYC, 2) - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(max_int(CS_HOLD_CYC, 1) - 1);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(max_int(GAP_CYC, 1) - 1);
    localparam logic [CNT_W-1:0] TMO_LD   = CNT_W'(max_int(TIMEOUT_CYC, 1) - 1);

    state_t           state, state_nxt;
    logic             tmr_load;
    logic [CNT_W-1:0] tmr_val;
    logic             tmr_done;

    logic             live;
    logic             rw_q;
    logic [6:0]       addr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       rdata_q;
    logic             err_q;
    logic             accept;

    adt7031_cyc_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign accept = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tmr_load  = 1'b0;
        tmr_val   = '0;
        unique case (state)
            ST_IDLE: begin
                if (accept) begin
                    state_nxt = ST_SETUP;
                    tmr_load  = 1'b1;
                    tmr_val   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (tmr_done) state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                state_nxt = ST_XFER;
                tmr_load  = 1'b1;
                tmr_val   = TMO_LD;
            end
            ST_XFER: begin
                if (spi_m_tvalid || tmr_done) begin
                    state_nxt = ST_HOLD;
                    tmr_load  = 1'b1;
                    tmr_val   = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (tmr_done) begin
                    state_nxt = ST_GAP;
                    tmr_load  = 1'b1;
                    tmr_val   = GAP_LD;
                end
            end
            ST_GAP: begin
                if (tmr_done) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A completion pulse wins over a timeout landing in the same cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            live    <= 1'b0;
            rw_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            live <= 1'b1;
            if (state == ST_IDLE && accept) begin
                rw_q    <= cmd_rw;
                addr_q  <= cmd_addr;
                wdata_q <= cmd_rw ? 8'h00 : cmd_wdata;
            end
            if (state == ST_XFER) begin
                if (spi_m_tvalid) begin
                    rdata_q <= rw_q ? spi_m_tdata[DATA_MSB:0] : 8'h00;
                    err_q   <= 1'b0;
                end else if (tmr_done) begin
                    rdata_q <= 8'h00;
                    err_q   <= 1'b1;
                end
            end
        end
    end

    assign cmd_ready    = live && (state == ST_IDLE);
    assign busy         = (state != ST_IDLE);
    assign spi_enable   = (state == ST_SETUP) || (state == ST_LOAD) ||
                          (state == ST_XFER)  || (state == ST_HOLD);
    assign spi_s_tvalid = (state == ST_LOAD);
    assign spi_config   = SPI_CFG;
    assign spi_m_tready = 1'b1;
    assign rsp_valid    = (state == ST_HOLD) && tmr_done;
    assign rsp_err      = rsp_valid && err_q;
    assign rsp_rdata    = rdata_q;

    always_comb begin
        spi_s_tdata                    = '0;
        spi_s_tdata[RW_BIT]            = rw_q;
        spi_s_tdata[ADDR_MSB:ADDR_LSB] = addr_q;
        spi_s_tdata[DATA_MSB:0]        = wdata_q;
    end

    logic unused_ok;
    assign unused_ok = &{1'b0, spi_s_tready, spi_m_tdata[SPI_WORD_W-1:DATA_MSB+1]};

endmodule
